// File: rtl/keypad_pkg.sv
// Shared keypad types and default row-bus constants, common to the debouncer and the keypad encoder.
package keypad_pkg;

  localparam int unsigned KP_ROW_WIDTH = 4;
  localparam logic [KP_ROW_WIDTH-1:0] KP_IDLE_CODE = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK_PRESS,
    S_PRESSED,
    S_CHECK_RELEASE
  } kp_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous multi-bit input bus.
// Both stages reset to IDLE_CODE, so the bus reads as idle out of reset.
module sync_2ff
  import keypad_pkg::*;
#(
  parameter int unsigned WIDTH = KP_ROW_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_CODE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= IDLE_CODE;
      sync_q <= IDLE_CODE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_row_debouncer.sv
// Keypad row debouncer: synchronises the row bus, then accepts a new code only after
// STABLE_SAMPLES identical samples, emitting one-cycle press/release strobes.
module keypad_row_debouncer
  import keypad_pkg::*;
#(
  parameter int unsigned WIDTH          = KP_ROW_WIDTH,
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned SAMPLE_DIV     = 1,
  parameter logic [WIDTH-1:0] IDLE_CODE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] filas_in,
  output logic [WIDTH-1:0] filas_stable,
  output logic             enable,
  output logic             press_pulse,
  output logic             release_pulse
);

  localparam int unsigned CW = $clog2(STABLE_SAMPLES + 1);
  localparam int unsigned PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] COMMIT_AT = CW'(STABLE_SAMPLES - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(STABLE_SAMPLES);
  localparam logic [PW-1:0] PRE_LAST  = PW'(SAMPLE_DIV - 1);

  logic [WIDTH-1:0] sample_c;
  logic             tick_c;
  logic [CW-1:0]    count_inc_c;

  kp_state_e        state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic             enable_q, enable_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  sync_2ff #(
    .WIDTH     (WIDTH),
    .IDLE_CODE (IDLE_CODE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (filas_in),
    .q_o (sample_c)
  );

  // With SAMPLE_DIV = 1 the prescaler is pinned at 0 and every cycle is a tick.
  assign tick_c      = (pre_q == PRE_LAST);
  assign pre_d       = tick_c ? '0 : pre_q + PW'(1);
  assign count_inc_c = (count_q == COUNT_MAX) ? count_q : count_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    count_d   = count_q;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick_c) begin
      case (state_q)
        S_IDLE: begin
          if (sample_c != IDLE_CODE) begin
            state_d = S_CHECK_PRESS;
            cand_d  = sample_c;
            count_d = CW'(1);
          end
        end
        S_CHECK_PRESS: begin
          if (sample_c == IDLE_CODE) begin
            state_d = S_IDLE;
            count_d = '0;
          end else if (sample_c != cand_q) begin
            cand_d  = sample_c;
            count_d = CW'(1);
          end else if (count_q == COMMIT_AT) begin
            stable_d = cand_q;
            press_d  = 1'b1;
            state_d  = S_PRESSED;
          end else begin
            count_d = count_inc_c;
          end
        end
        S_PRESSED: begin
          if (sample_c != stable_q) begin
            state_d = S_CHECK_RELEASE;
            cand_d  = sample_c;
            count_d = CW'(1);
          end
        end
        S_CHECK_RELEASE: begin
          if (sample_c == stable_q) begin
            state_d = S_PRESSED;
            count_d = '0;
          end else if (sample_c != cand_q) begin
            cand_d  = sample_c;
            count_d = CW'(1);
          end else if (count_q == COMMIT_AT) begin
            // A direct key change releases the old code and presses the new one together.
            stable_d  = cand_q;
            release_d = 1'b1;
            press_d   = (cand_q != IDLE_CODE);
            state_d   = (cand_q == IDLE_CODE) ? S_IDLE : S_PRESSED;
          end else begin
            count_d = count_inc_c;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    enable_d = (state_d == S_IDLE) || (state_d == S_PRESSED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      count_q   <= '0;
      cand_q    <= IDLE_CODE;
      stable_q  <= IDLE_CODE;
      enable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      count_q   <= count_d;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      enable_q  <= enable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign filas_stable  = stable_q;
  assign enable        = enable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_keypad_row_debouncer.sv
// Bench for keypad_row_debouncer: two instances (SAMPLE_DIV 1 and 3) checked every cycle
// against a run-length model of the debounce rules, plus scenario-specific checks.
module tb_keypad_row_debouncer;

  localparam int W  = 4;
  localparam int SS = 4;
  localparam logic [W-1:0] IDLE = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] filas_in = IDLE;

  logic [W-1:0] stable0, stable1;
  logic en0, en1, pr0, pr1, rl0, rl1;
  logic [W+2:0] obs [2];

  int n_vec = 0;
  int n_err = 0;

  int sd [2] = '{1, 3};
  logic [W-1:0] m_s1 [2], m_s2 [2], m_stable [2], m_last [2], m_runval [2];
  int m_run [2], m_cnt [2];
  logic m_en [2], m_press [2], m_rel [2];

  always #5 clk = ~clk;

  keypad_row_debouncer #(.WIDTH(W), .STABLE_SAMPLES(SS), .SAMPLE_DIV(1), .IDLE_CODE(IDLE)) dut0 (
    .clk(clk), .rst(rst), .filas_in(filas_in), .filas_stable(stable0),
    .enable(en0), .press_pulse(pr0), .release_pulse(rl0));

  keypad_row_debouncer #(.WIDTH(W), .STABLE_SAMPLES(SS), .SAMPLE_DIV(3), .IDLE_CODE(IDLE)) dut1 (
    .clk(clk), .rst(rst), .filas_in(filas_in), .filas_stable(stable1),
    .enable(en1), .press_pulse(pr1), .release_pulse(rl1));

  assign obs[0] = {stable0, en0, pr0, rl0};
  assign obs[1] = {stable1, en1, pr1, rl1};

  function automatic logic [W+2:0] expv(input int d);
    return {m_stable[d], m_en[d], m_press[d], m_rel[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_s1[d] = IDLE; m_s2[d] = IDLE; m_stable[d] = IDLE; m_last[d] = IDLE;
      m_runval[d] = IDLE; m_run[d] = 0; m_cnt[d] = 0;
      m_en[d] = 1'b0; m_press[d] = 1'b0; m_rel[d] = 1'b0;
    end
  endtask

  // A code is accepted once it has been seen on SS consecutive sample ticks and differs from the output.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic tick;
      logic [W-1:0] x;
      tick = (m_cnt[d] % sd[d]) == (sd[d] - 1);
      m_cnt[d]++;
      m_press[d] = 1'b0;
      m_rel[d]   = 1'b0;
      if (tick) begin
        x = m_s2[d];
        if (x == m_runval[d]) m_run[d]++;
        else begin
          m_runval[d] = x;
          m_run[d]    = 1;
        end
        if (x != m_stable[d] && m_run[d] >= SS) begin
          m_press[d]  = (x != IDLE);
          m_rel[d]    = (m_stable[d] != IDLE);
          m_stable[d] = x;
        end
        m_last[d] = x;
      end
      m_s2[d] = m_s1[d];
      m_s1[d] = filas_in;
      m_en[d] = (m_last[d] == m_stable[d]);
    end
  endtask

  task automatic step(input logic [W-1:0] v);
    filas_in = v;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    #1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    filas_in = IDLE;
    rst = 1'b1;
    model_reset();
    #1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (obs[d] !== '0) begin
          n_err++;
          $display("FAIL reset_hold dut%0d cyc %0d: got %b want %b", d, c, obs[d], 7'b0);
        end
      end
    end
    rst = 1'b0;
    step(IDLE);
    n_vec++;
    if (en0 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_edge_enable: got %b want 1", en0);
    end
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (obs[d] !== expv(d)) begin
        n_err++;
        $display("FAIL reset_release dut%0d: got %b want %b", d, obs[d], expv(d));
      end
    end
  endtask

  task automatic test_press();
    int press_edge = -1;
    int npress = 0;
    for (int e = 1; e <= 10; e++) begin
      step(4'b0100);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (obs[d] !== expv(d)) begin
          n_err++;
          $display("FAIL press dut%0d edge %0d: got %b want %b", d, e, obs[d], expv(d));
        end
      end
      if (e >= 3 && e <= 5) begin
        n_vec++;
        if (en0 !== 1'b0) begin
          n_err++;
          $display("FAIL press_enable_low edge %0d: got %b want 0", e, en0);
        end
      end
      if (pr0 === 1'b1) begin
        npress++;
        if (press_edge < 0) press_edge = e;
      end
    end
    n_vec++;
    if (press_edge != 6 || npress != 1) begin
      n_err++;
      $display("FAIL press_timing: got edge %0d count %0d want edge 6 count 1", press_edge, npress);
    end
    n_vec++;
    if (stable0 !== 4'b0100) begin
      n_err++;
      $display("FAIL press_code: got %b want 0100", stable0);
    end
  endtask

  task automatic test_bounce();
    int np0 = 0;
    int np1 = 0;
    do_reset(2);
    for (int i = 0; i < 28; i++) begin
      logic [W-1:0] v;
      v = (i < 20 && ((i / 2) % 2) == 0) ? 4'b0100 : IDLE;
      step(v);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (obs[d] !== expv(d)) begin
          n_err++;
          $display("FAIL bounce dut%0d cyc %0d: got %b want %b", d, i, obs[d], expv(d));
        end
      end
      if (pr0 === 1'b1) np0++;
      if (pr1 === 1'b1) np1++;
    end
    n_vec++;
    if (np0 != 0 || np1 != 0 || stable0 !== IDLE || stable1 !== IDLE) begin
      n_err++;
      $display("FAIL bounce_reject: got presses %0d/%0d codes %b/%b want 0/0 0000/0000",
               np0, np1, stable0, stable1);
    end
  endtask

  task automatic test_release();
    int nrel = 0;
    int both = 0;
    logic [W-1:0] seq [4] = '{4'b0100, 4'b0000, 4'b0100, 4'b0010};
    do_reset(2);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 8; i++) begin
        step(seq[p]);
        for (int d = 0; d < 2; d++) begin
          n_vec++;
          if (obs[d] !== expv(d)) begin
            n_err++;
            $display("FAIL release dut%0d phase %0d cyc %0d: got %b want %b", d, p, i, obs[d], expv(d));
          end
        end
        if (p == 1 && rl0 === 1'b1) nrel++;
        if (p == 3 && rl0 === 1'b1 && pr0 === 1'b1) both++;
      end
      if (p == 1) begin
        n_vec++;
        if (nrel != 1 || stable0 !== IDLE) begin
          n_err++;
          $display("FAIL release_to_idle: got pulses %0d code %b want 1 0000", nrel, stable0);
        end
      end
    end
    n_vec++;
    if (both != 1 || stable0 !== 4'b0010) begin
      n_err++;
      $display("FAIL key_change: got dual pulses %0d code %b want 1 0010", both, stable0);
    end
  endtask

  task automatic test_prescaler();
    int press_edge = -1;
    int npress = 0;
    int nrel = 0;
    do_reset(2);
    for (int e = 1; e <= 45; e++) begin
      logic [W-1:0] v;
      v = (e == 31 || e == 32) ? IDLE : 4'b1000;
      step(v);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (obs[d] !== expv(d)) begin
          n_err++;
          $display("FAIL prescaler dut%0d edge %0d: got %b want %b", d, e, obs[d], expv(d));
        end
      end
      if (pr1 === 1'b1) begin
        npress++;
        if (press_edge < 0) press_edge = e;
      end
      if (rl1 === 1'b1) nrel++;
    end
    n_vec++;
    if (press_edge != 12 || npress != 1) begin
      n_err++;
      $display("FAIL prescaler_press: got edge %0d count %0d want edge 12 count 1", press_edge, npress);
    end
    n_vec++;
    if (nrel != 0 || stable1 !== 4'b1000) begin
      n_err++;
      $display("FAIL prescaler_glitch: got releases %0d code %b want 0 1000", nrel, stable1);
    end
  endtask

  task automatic test_reset_mid();
    int press_edge = -1;
    int npress = 0;
    do_reset(2);
    for (int e = 1; e <= 4; e++) step(4'b0001);
    n_vec++;
    if (en0 !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_in_check: got enable %b want 0", en0);
    end
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (obs[d] !== '0) begin
        n_err++;
        $display("FAIL midreset_clear dut%0d: got %b want %b", d, obs[d], 7'b0);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step(4'b0001);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (obs[d] !== expv(d)) begin
          n_err++;
          $display("FAIL midreset dut%0d edge %0d: got %b want %b", d, e, obs[d], expv(d));
        end
      end
      if (pr0 === 1'b1) begin
        npress++;
        if (press_edge < 0) press_edge = e;
      end
    end
    n_vec++;
    if (press_edge != 6 || npress != 1) begin
      n_err++;
      $display("FAIL midreset_repress: got edge %0d count %0d want edge 6 count 1", press_edge, npress);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    int hold;
    do_reset(1);
    hold = 0;
    v = IDLE;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        v = ($urandom_range(0, 2) == 0) ? IDLE : W'($urandom_range(0, 15));
        hold = ($urandom_range(0, 3) == 0) ? 16 : $urandom_range(1, 6);
      end
      hold--;
      step(v);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (obs[d] !== expv(d)) begin
          n_err++;
          $display("FAIL random dut%0d cyc %0d in %b: got %b want %b", d, c, v, obs[d], expv(d));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_release();
    test_prescaler();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
